// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data_mem port between the MEM stage and the debug/loader port
// MEM stage has priority; starvation and burst counters bound the wait on both sides.
module dmem_arbiter #(
  parameter int DBG_MAX_WAIT = 4,
  parameter int DBG_BURST    = 2,
  parameter int AW           = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam int WW = $clog2(DBG_MAX_WAIT + 1);
  localparam int BW = $clog2(DBG_BURST + 1);

  typedef enum logic {S_CPU, S_DBG} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          grant_dbg;

  always_comb begin
    grant_dbg = 1'b0;
    if (state == S_CPU)
      grant_dbg = dbg_valid & (~cpu_req | (wait_cnt == WW'(DBG_MAX_WAIT)));
    else
      grant_dbg = dbg_valid & (~cpu_req | (burst_cnt < BW'(DBG_BURST)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // A denial on the cycle a burst ends already counts as one cycle of debug wait,
  // so the wait bound holds across back-to-back bursts.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    wait_nxt  = '0;
    if (dbg_valid && !grant_dbg)
      wait_nxt = (wait_cnt == WW'(DBG_MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);
    case (state)
      S_CPU: begin
        if (grant_dbg && cpu_req) begin
          state_nxt = S_DBG;
          burst_nxt = BW'(1);
        end
      end
      S_DBG: begin
        if (!grant_dbg) begin
          state_nxt = S_CPU;
          burst_nxt = '0;
        end else if (cpu_req) begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      default: begin
        state_nxt = S_CPU;
        burst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we & cpu_req;
    dbg_ready = 1'b0;
    cpu_stall = 1'b0;
    if (!rst_n) begin
      mem_we    = 1'b0;
      cpu_stall = cpu_req;
    end else if (grant_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      dbg_ready = 1'b1;
      cpu_stall = cpu_req;
    end
  end

  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= grant_dbg & ~dbg_we;
      if (grant_dbg && !dbg_we)
        dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
// Stimulus pushes predicted responses; a monitor pops and compares on the falling edge.
module tb_dmem_arbiter;

  localparam int MAXW  = 4;
  localparam int BURST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_valid = 1'b0, dbg_we = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ready, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  dmem_arbiter #(.DBG_MAX_WAIT(MAXW), .DBG_BURST(BURST), .AW(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // data_mem: falling-edge sampled, read-before-write
  logic [31:0] mem [0:511];
  always @(negedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rvalid;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        cyc_q[$];
  logic [32:0] dbg_q[$];

  logic [31:0] refm  [0:511];
  bit          known [0:511];
  int          denied = 0, forced = 0;
  bit          rd_pending = 0, last_grant = 0;
  int          checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: debug wins when the CPU is idle, after MAXW denied cycles, or while
  // a forced burst has fewer than BURST stall cycles behind it.
  task automatic step(input bit creq, input bit cwe, input logic [8:0] caddr, input logic [31:0] cwd,
                      input bit dv, input bit dwe, input logic [8:0] daddr, input logic [31:0] dwd);
    exp_t e;
    bit   g;
    @(posedge clk); #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_valid = dv; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    g = 0;
    e.chk_rdata = 0;
    e.rdata = '0;
    if (!rst_n) begin
      e.stall = creq; e.ready = 0; e.rvalid = 0;
      denied = 0; forced = 0; rd_pending = 0;
      dbg_q.delete();
    end else begin
      if (forced > 0) g = dv && (!creq || forced < BURST);
      else            g = dv && (!creq || denied >= MAXW);
      e.stall  = g && creq;
      e.ready  = g;
      e.rvalid = rd_pending;
      e.chk_rdata = !g && creq && !cwe && known[caddr];
      e.rdata  = refm[caddr];
      if (g && !dwe) dbg_q.push_back({known[daddr], refm[daddr]});
      if (g && dwe) begin
        refm[daddr] = dwd; known[daddr] = 1;
      end else if (!g && creq && cwe) begin
        refm[caddr] = cwd; known[caddr] = 1;
      end
      rd_pending = g && !dwe;
      if (g || !dv) denied = 0;
      else if (denied < MAXW) denied++;
      if (!g) forced = 0;
      else if (creq) forced++;
    end
    last_grant = g;
    cyc_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [32:0] d;
    forever begin
      @(negedge clk); #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
        check("dbg_ready", {31'd0, dbg_ready}, {31'd0, e.ready});
        check("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e.rvalid});
        if (e.chk_rdata) check("cpu_rdata", cpu_rdata, e.rdata);
        if (dbg_rvalid === 1'b1) begin
          if (dbg_q.size() == 0) begin
            check("dbg_rvalid_unexpected", 32'd1, 32'd0);
          end else begin
            d = dbg_q.pop_front();
            if (d[32]) check("dbg_rdata", dbg_rdata, d[31:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int grants;
    bit pv, pwe;
    logic [8:0] pa;
    logic [31:0] pd;
    for (int i = 0; i < 512; i++) begin
      refm[i] = '0; known[i] = 0;
    end
    #12;
    check("reset_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("reset_rdata", dbg_rdata, 32'd0);
    check("reset_ready", {31'd0, dbg_ready}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_valid = 1'b1;
    #1;
    check("reset_stall", {31'd0, cpu_stall}, 32'd1);
    check("reset_mem_we_req", {31'd0, mem_we}, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_valid = 1'b0;
    @(negedge clk); #3 rst_n = 1'b1;

    // CPU only
    step(1, 1, 9'h010, 32'hDEADBEEF, 0, 0, 9'h0, 32'h0);
    step(1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
    @(negedge clk); #2;
    check("cpu_load_0x010", cpu_rdata, 32'hDEADBEEF);

    // Debug only
    step(0, 0, 9'h0, 32'h0, 1, 1, 9'h1FF, 32'h12345678);
    step(0, 0, 9'h0, 32'h0, 1, 0, 9'h1FF, 32'h0);
    step(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    @(negedge clk); #2;
    check("dbg_read_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    check("dbg_read_0x1FF", dbg_rdata, 32'h12345678);

    // Starvation under continuous cpu_req
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 9'h010, 32'h0, 1, 1, 9'h020, 32'hA5A5_0000);
      @(negedge clk); #2;
      check($sformatf("starve_ready_c%0d", i), {31'd0, dbg_ready},
            {31'd0, (i == 4 || i == 5 || i == 10 || i == 11)});
    end
    step(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);

    // Idle CPU: every debug request is granted for free
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 9'h0, 32'h0, 1, 0, 9'h1FF, 32'h0);
      @(negedge clk); #2;
      if (dbg_ready === 1'b1 && cpu_stall === 1'b0) grants++;
    end
    check("idle_grants", grants, 32'd8);
    // Still S_CPU with no accumulated wait: the CPU wins a simultaneous request
    step(1, 0, 9'h010, 32'h0, 1, 0, 9'h1FF, 32'h0);
    @(negedge clk); #2;
    check("simul_cpu_wins", {31'd0, dbg_ready}, 32'd0);
    step(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);

    // Reset between a debug read grant and its response
    step(0, 0, 9'h0, 32'h0, 1, 0, 9'h1FF, 32'h0);
    @(negedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("rst_mid_ready", {31'd0, dbg_ready}, 32'd0);
    step(1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
    step(1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
    @(negedge clk); #3 rst_n = 1'b1;
    step(1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
    @(negedge clk); #2;
    check("post_rst_load", cpu_rdata, 32'hDEADBEEF);
    check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);

    // Randomized traffic; debug requests hold steady until accepted
    pv = 0; pwe = 0; pa = '0; pd = '0;
    for (int i = 0; i < 2000; i++) begin
      bit creq, cwe;
      logic [8:0] ca;
      int r;
      if (!pv && ($urandom % 3 == 0)) begin
        pv = 1; pwe = $urandom % 2 == 0;
        r = $urandom_range(0, 31);
        pa = (r < 16) ? 9'(r) : 9'(9'h1E0 + r);
        pd = $urandom;
      end
      creq = ($urandom % 4) != 0;
      cwe = $urandom % 2 == 0;
      r = $urandom_range(0, 31);
      ca = (r < 16) ? 9'(r) : 9'(9'h1E0 + r);
      step(creq, cwe, ca, $urandom, pv, pwe, pa, pd);
      if (last_grant) pv = 0;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    @(negedge clk); #3;
    check("cyc_q_drained", cyc_q.size(), 32'd0);
    check("dbg_q_drained", dbg_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
